// File: rtl/operand_dispatch.sv
// Single-entry dispatch register between operand fetch and the reservation stations.
// Holds one instruction, snoops the CDB while stalled; DISPATCH_PERF_EN adds a stall counter.
module operand_dispatch #(
  parameter int unsigned NUM_RS = 5,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ROB_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        RS_id_i,
  input  logic [6:0]        OP_i,
  input  logic [2:0]        Funct3_i,
  input  logic [6:0]        Funct7_i,
  input  logic [XLEN-1:0]   Imm_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [ROB_W-1:0]  ROB_id_i,
  input  logic              data1_rdy_i,
  input  logic [XLEN-1:0]   data1_i,
  input  logic [ROB_W-1:0]  data1_rid_i,
  input  logic              data2_rdy_i,
  input  logic [XLEN-1:0]   data2_i,
  input  logic [ROB_W-1:0]  data2_rid_i,
  input  logic              cdb_valid_i,
  input  logic [ROB_W-1:0]  cdb_rob_id_i,
  input  logic [XLEN-1:0]   cdb_data_i,
  input  logic [NUM_RS-1:0] rs_full_i,
  output logic [NUM_RS-1:0] rs_we_o,
  output logic [6:0]        rs_op_o,
  output logic [2:0]        rs_funct3_o,
  output logic [6:0]        rs_funct7_o,
  output logic [XLEN-1:0]   rs_imm_o,
  output logic [XLEN-1:0]   rs_pc_o,
  output logic [ROB_W-1:0]  rs_rob_id_o,
  output logic [XLEN-1:0]   rs_vj_o,
  output logic [ROB_W-1:0]  rs_qj_o,
  output logic              rs_rj_o,
  output logic [XLEN-1:0]   rs_vk_o,
  output logic [ROB_W-1:0]  rs_qk_o,
  output logic              rs_rk_o,
  output logic              err_rs_id_o
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  typedef enum logic [0:0] {StEmpty, StHeld} state_e;

  state_e            state_q;
  logic [2:0]        rs_id_q;
  logic [6:0]        op_q;
  logic [2:0]        funct3_q;
  logic [6:0]        funct7_q;
  logic [XLEN-1:0]   imm_q;
  logic [XLEN-1:0]   pc_q;
  logic [ROB_W-1:0]  rob_id_q;
  logic [XLEN-1:0]   vj_q;
  logic [ROB_W-1:0]  qj_q;
  logic              rj_q;
  logic [XLEN-1:0]   vk_q;
  logic [ROB_W-1:0]  qk_q;
  logic              rk_q;
  logic              err_q;

  logic              valid_q;
  logic              id_legal;
  logic              id_full;
  logic [NUM_RS-1:0] we_onehot;
  logic              fire;
  logic              go;
  logic              cap;
  logic              hit_j;
  logic              hit_k;
  logic              in_hit1;
  logic              in_hit2;

  assign valid_q = (state_q == StHeld);

  // Decode the held RS index without ever indexing rs_full_i out of range.
  always_comb begin
    id_legal  = 1'b0;
    id_full   = 1'b0;
    we_onehot = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (rs_id_q == 3'(i)) begin
        id_legal     = 1'b1;
        id_full      = rs_full_i[i];
        we_onehot[i] = 1'b1;
      end
    end
  end

  assign fire    = valid_q && (!id_legal || !id_full);
  assign go      = fire && !flush_i;
  assign ready_o = flush_i || !valid_q || fire;
  assign cap     = valid_i && ready_o && !flush_i;
  assign rs_we_o = go ? we_onehot : '0;

  // Same-cycle CDB forwarding for held operands that are still waiting.
  assign hit_j   = valid_q && !rj_q && cdb_valid_i && (cdb_rob_id_i == qj_q);
  assign hit_k   = valid_q && !rk_q && cdb_valid_i && (cdb_rob_id_i == qk_q);
  assign rs_rj_o = rj_q || hit_j;
  assign rs_rk_o = rk_q || hit_k;
  assign rs_vj_o = hit_j ? cdb_data_i : vj_q;
  assign rs_vk_o = hit_k ? cdb_data_i : vk_q;
  assign rs_qj_o = qj_q;
  assign rs_qk_o = qk_q;

  assign in_hit1 = cdb_valid_i && (cdb_rob_id_i == data1_rid_i);
  assign in_hit2 = cdb_valid_i && (cdb_rob_id_i == data2_rid_i);

  assign rs_op_o     = op_q;
  assign rs_funct3_o = funct3_q;
  assign rs_funct7_o = funct7_q;
  assign rs_imm_o    = imm_q;
  assign rs_pc_o     = pc_q;
  assign rs_rob_id_o = rob_id_q;
  assign err_rs_id_o = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      rs_id_q  <= '0;
      op_q     <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      rob_id_q <= '0;
      vj_q     <= '0;
      qj_q     <= '0;
      rj_q     <= 1'b0;
      vk_q     <= '0;
      qk_q     <= '0;
      rk_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= go && !id_legal;
      if (flush_i) begin
        state_q <= StEmpty;
      end else if (cap) begin
        state_q  <= StHeld;
        rs_id_q  <= RS_id_i;
        op_q     <= OP_i;
        funct3_q <= Funct3_i;
        funct7_q <= Funct7_i;
        imm_q    <= Imm_i;
        pc_q     <= pc_i;
        rob_id_q <= ROB_id_i;
        qj_q     <= data1_rid_i;
        rj_q     <= data1_rdy_i || in_hit1;
        vj_q     <= (!data1_rdy_i && in_hit1) ? cdb_data_i : data1_i;
        qk_q     <= data2_rid_i;
        rk_q     <= data2_rdy_i || in_hit2;
        vk_q     <= (!data2_rdy_i && in_hit2) ? cdb_data_i : data2_i;
      end else if (go) begin
        state_q <= StEmpty;
      end else if (valid_q) begin
        vj_q <= rs_vj_o;
        rj_q <= rs_rj_o;
        vk_q <= rs_vk_o;
        rk_q <= rs_rk_o;
      end
    end
  end

`ifdef DISPATCH_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (valid_q && !fire && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_dispatch.sv
// Bench for operand_dispatch: directed scenarios then random traffic against a cycle model
// of the held instruction (valid flag, payload, two operand records).
module tb_operand_dispatch;
  localparam int NUM_RS = 5;
  localparam int XLEN   = 32;
  localparam int ROB_W  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              flush_i, valid_i, ready_o;
  logic [2:0]        RS_id_i;
  logic [6:0]        OP_i, Funct7_i;
  logic [2:0]        Funct3_i;
  logic [XLEN-1:0]   Imm_i, pc_i, data1_i, data2_i, cdb_data_i;
  logic [ROB_W-1:0]  ROB_id_i, data1_rid_i, data2_rid_i, cdb_rob_id_i;
  logic              data1_rdy_i, data2_rdy_i, cdb_valid_i;
  logic [NUM_RS-1:0] rs_full_i, rs_we_o;
  logic [6:0]        rs_op_o, rs_funct7_o;
  logic [2:0]        rs_funct3_o;
  logic [XLEN-1:0]   rs_imm_o, rs_pc_o, rs_vj_o, rs_vk_o;
  logic [ROB_W-1:0]  rs_rob_id_o, rs_qj_o, rs_qk_o;
  logic              rs_rj_o, rs_rk_o, err_rs_id_o;
`ifdef DISPATCH_PERF_EN
  logic [31:0]       stall_cnt_o;
`endif

  operand_dispatch #(.NUM_RS(NUM_RS), .XLEN(XLEN), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .RS_id_i(RS_id_i), .OP_i(OP_i), .Funct3_i(Funct3_i), .Funct7_i(Funct7_i),
    .Imm_i(Imm_i), .pc_i(pc_i), .ROB_id_i(ROB_id_i),
    .data1_rdy_i(data1_rdy_i), .data1_i(data1_i), .data1_rid_i(data1_rid_i),
    .data2_rdy_i(data2_rdy_i), .data2_i(data2_i), .data2_rid_i(data2_rid_i),
    .cdb_valid_i(cdb_valid_i), .cdb_rob_id_i(cdb_rob_id_i), .cdb_data_i(cdb_data_i),
    .rs_full_i(rs_full_i), .rs_we_o(rs_we_o),
    .rs_op_o(rs_op_o), .rs_funct3_o(rs_funct3_o), .rs_funct7_o(rs_funct7_o),
    .rs_imm_o(rs_imm_o), .rs_pc_o(rs_pc_o), .rs_rob_id_o(rs_rob_id_o),
    .rs_vj_o(rs_vj_o), .rs_qj_o(rs_qj_o), .rs_rj_o(rs_rj_o),
    .rs_vk_o(rs_vk_o), .rs_qk_o(rs_qk_o), .rs_rk_o(rs_rk_o),
    .err_rs_id_o(err_rs_id_o)
`ifdef DISPATCH_PERF_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model of the held instruction
  bit               m_valid, m_err;
  int               m_rs;
  logic [6:0]       m_op, m_f7;
  logic [2:0]       m_f3;
  logic [XLEN-1:0]  m_imm, m_pc;
  logic [ROB_W-1:0] m_rob;
  logic [XLEN-1:0]  m_v [2];
  logic [ROB_W-1:0] m_q [2];
  bit               m_r [2];
  longint           m_stall;
  // Expectations for the current cycle
  bit               e_legal, e_fire, e_go, e_ready;
  logic [XLEN-1:0]  e_v [2];
  bit               e_r [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_valid = 0; m_err = 0; m_rs = 0; m_stall = 0;
    m_op = '0; m_f3 = '0; m_f7 = '0; m_imm = '0; m_pc = '0; m_rob = '0;
    for (int k = 0; k < 2; k++) begin
      m_v[k] = '0; m_q[k] = '0; m_r[k] = 0;
    end
  endtask

  task automatic idle();
    valid_i = 0; flush_i = 0; cdb_valid_i = 0; cdb_rob_id_i = '0; cdb_data_i = '0;
    rs_full_i = '0;
  endtask

  task automatic put(input int id, input bit r1, input logic [XLEN-1:0] d1, input int t1,
                     input bit r2, input logic [XLEN-1:0] d2, input int t2);
    valid_i = 1; RS_id_i = 3'(id);
    OP_i = 7'($urandom); Funct3_i = 3'($urandom); Funct7_i = 7'($urandom);
    Imm_i = $urandom; pc_i = $urandom; ROB_id_i = ROB_W'($urandom);
    data1_rdy_i = r1; data1_i = d1; data1_rid_i = ROB_W'(t1);
    data2_rdy_i = r2; data2_i = d2; data2_rid_i = ROB_W'(t2);
  endtask

  task automatic cdb(input bit v, input int tag, input logic [XLEN-1:0] d);
    cdb_valid_i = v; cdb_rob_id_i = ROB_W'(tag); cdb_data_i = d;
  endtask

  // Derive expectations from the model and current inputs, compare at the falling edge.
  task automatic at_neg();
    logic [NUM_RS-1:0] e_we;
    bit full, hit;
    @(negedge clk);
    e_legal = (m_rs < NUM_RS);
    full    = e_legal ? rs_full_i[m_rs] : 1'b0;
    e_fire  = m_valid && !full;
    e_go    = e_fire && !flush_i;
    e_ready = flush_i || !m_valid || e_fire;
    e_we    = '0;
    if (e_go && e_legal) e_we[m_rs] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      hit    = m_valid && !m_r[k] && cdb_valid_i && (cdb_rob_id_i == m_q[k]);
      e_r[k] = m_r[k] || hit;
      e_v[k] = hit ? cdb_data_i : m_v[k];
    end
    chk("ready", 64'(ready_o), 64'(e_ready));
    chk("rs_we", 64'(rs_we_o), 64'(e_we));
    chk("err", 64'(err_rs_id_o), 64'(m_err));
    if (m_valid) begin
      chk("op", 64'(rs_op_o), 64'(m_op));
      chk("f3", 64'(rs_funct3_o), 64'(m_f3));
      chk("f7", 64'(rs_funct7_o), 64'(m_f7));
      chk("imm", 64'(rs_imm_o), 64'(m_imm));
      chk("pc", 64'(rs_pc_o), 64'(m_pc));
      chk("rob", 64'(rs_rob_id_o), 64'(m_rob));
      chk("qj", 64'(rs_qj_o), 64'(m_q[0]));
      chk("qk", 64'(rs_qk_o), 64'(m_q[1]));
      chk("rj", 64'(rs_rj_o), 64'(e_r[0]));
      chk("rk", 64'(rs_rk_o), 64'(e_r[1]));
      if (e_r[0]) chk("vj", 64'(rs_vj_o), 64'(e_v[0]));
      if (e_r[1]) chk("vk", 64'(rs_vk_o), 64'(e_v[1]));
    end
`ifdef DISPATCH_PERF_EN
    chk("stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
`endif
  endtask

  // Advance the model across the rising edge.
  task automatic adv();
    bit stalled;
    stalled = m_valid && !e_fire && !flush_i;
    m_err   = e_go && !e_legal;
    if (stalled && m_stall != 64'hFFFF_FFFF) m_stall++;
    if (flush_i) begin
      m_valid = 0;
    end else if (valid_i && e_ready) begin
      m_valid = 1; m_rs = int'(RS_id_i);
      m_op = OP_i; m_f3 = Funct3_i; m_f7 = Funct7_i; m_imm = Imm_i; m_pc = pc_i;
      m_rob = ROB_id_i;
      m_q[0] = data1_rid_i; m_q[1] = data2_rid_i;
      m_r[0] = data1_rdy_i || (cdb_valid_i && cdb_rob_id_i == data1_rid_i);
      m_r[1] = data2_rdy_i || (cdb_valid_i && cdb_rob_id_i == data2_rid_i);
      m_v[0] = data1_rdy_i ? data1_i : cdb_data_i;
      m_v[1] = data2_rdy_i ? data2_i : cdb_data_i;
    end else if (e_go) begin
      m_valid = 0;
    end else if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        m_r[k] = e_r[k]; m_v[k] = e_v[k];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    at_neg();
    adv();
  endtask

  initial begin
    idle();
    put(0, 1, '0, 0, 1, '0, 0);
    valid_i = 0;
    mreset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_we", 64'(rs_we_o), 64'd0);
    chk("rst_err", 64'(err_rs_id_o), 64'd0);
    chk("rst_vj", 64'(rs_vj_o), 64'd0);
    chk("rst_op", 64'(rs_op_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1;

    // Basic capture and dispatch to RS 2
    put(2, 1, 32'h11, 0, 1, 32'h22, 0);
    step();
    idle();
    at_neg();
    chk("t1_we", 64'(rs_we_o), 64'b00100);
    chk("t1_vj", 64'(rs_vj_o), 64'h11);
    chk("t1_vk", 64'(rs_vk_o), 64'h22);
    adv();

    // Held operand woken by CDB while RS 1 is full; later stale broadcast ignored
    put(1, 0, 32'h0, 7, 1, 32'h33, 0);
    rs_full_i = 5'b00010;
    step();
    idle(); rs_full_i = 5'b00010;
    step();
    cdb(1, 7, 32'hABCD);
    step();
    cdb(1, 7, 32'h9999);
    step();
    idle();
    at_neg();
    chk("t2_we", 64'(rs_we_o), 64'b00010);
    chk("t2_rj", 64'(rs_rj_o), 64'd1);
    chk("t2_vj", 64'(rs_vj_o), 64'hABCD);
    adv();

    // CDB match at capture time
    put(3, 1, 32'h1, 0, 0, 32'h0, 4);
    cdb(1, 4, 32'h55);
    step();
    idle();
    at_neg();
    chk("t3_we", 64'(rs_we_o), 64'b01000);
    chk("t3_rk", 64'(rs_rk_o), 64'd1);
    chk("t3_vk", 64'(rs_vk_o), 64'h55);
    adv();

    // Back-to-back stream
    for (int i = 0; i < 4; i++) begin
      put(i, 1, $urandom, 0, 1, $urandom, 0);
      at_neg();
      chk("t4_ready", 64'(ready_o), 64'd1);
      if (i > 0) chk("t4_we", 64'(rs_we_o), 64'(1) << (i - 1));
      adv();
    end
    idle();
    at_neg();
    chk("t4_we_last", 64'(rs_we_o), 64'b01000);
    adv();

    // Flush while stalled with a new instruction offered
    put(0, 1, 32'h5, 0, 1, 32'h6, 0);
    rs_full_i = 5'b00001;
    step();
    idle(); rs_full_i = 5'b00001;
    step();
    put(2, 1, 32'h7, 0, 1, 32'h8, 0);
    flush_i = 1; rs_full_i = '0;
    at_neg();
    chk("t5_flush_we", 64'(rs_we_o), 64'd0);
    chk("t5_flush_ready", 64'(ready_o), 64'd1);
    adv();
    idle();
    at_neg();
    chk("t5_after_we", 64'(rs_we_o), 64'd0);
    adv();

    // Illegal RS id: consumed without write, error pulse one cycle later
    put(6, 1, 32'h1, 0, 1, 32'h2, 0);
    step();
    idle();
    at_neg();
    chk("t6_we", 64'(rs_we_o), 64'd0);
    chk("t6_ready", 64'(ready_o), 64'd1);
    adv();
    at_neg();
    chk("t6_err", 64'(err_rs_id_o), 64'd1);
    adv();
    at_neg();
    chk("t6_err_clr", 64'(err_rs_id_o), 64'd0);
    adv();

    // Asynchronous reset in the middle of a stall
    put(4, 1, 32'h9, 0, 0, 32'h0, 3);
    rs_full_i = 5'b10000;
    step();
    idle(); rs_full_i = 5'b10000;
    step();
    step();
    #2;
    rst_n = 0;
    rs_full_i = '0;
    #1;
    chk("t7_we", 64'(rs_we_o), 64'd0);
    chk("t7_ready", 64'(ready_o), 64'd1);
    chk("t7_rk", 64'(rs_rk_o), 64'd0);
    chk("t7_vj", 64'(rs_vj_o), 64'd0);
    chk("t7_imm", 64'(rs_imm_o), 64'd0);
`ifdef DISPATCH_PERF_EN
    chk("t7_stall", 64'(stall_cnt_o), 64'd0);
`endif
    mreset();
    @(posedge clk);
    #1;
    rst_n = 1;
    step();

    // Five stall cycles
    put(1, 1, 32'h3, 0, 1, 32'h4, 0);
    rs_full_i = 5'b00010;
    step();
    idle(); rs_full_i = 5'b00010;
    repeat (5) step();
    at_neg();
`ifdef DISPATCH_PERF_EN
    chk("t8_stall5", 64'(stall_cnt_o), 64'd5);
`endif
    chk("t8_we_blocked", 64'(rs_we_o), 64'd0);
    adv();
    rs_full_i = '0;
    step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0)
        put($urandom_range(0, 7), 1'($urandom), $urandom, $urandom_range(0, 7),
            1'($urandom), $urandom, $urandom_range(0, 7));
      else
        valid_i = 0;
      cdb(($urandom_range(0, 1) == 1), $urandom_range(0, 7), $urandom);
      for (int b = 0; b < NUM_RS; b++) rs_full_i[b] = ($urandom_range(0, 9) < 3);
      flush_i = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
